fft_pa2se: RTL and testbench

- Parallel-to-serial output stage directly downstream of HADAMARD in the FFT32 pipeline.
- Accepts each 32-point frame as 8 consecutive 4-lane words, starting with the cycle HADAMARD pulses its done strobe.
- Stores frames in a ping-pong buffer of two 32-entry banks, optionally undoing bit-reversed ordering.
- Emits one complex sample per cycle, with a frame-start strobe and a valid flag, to the serial output of FFT32.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_pa2se_bank.sv | 46 ++++
 rtl/fft_pa2se.sv | 199 +++++++++++++++++++
 tb/tb_fft_pa2se.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, state encodings and the 5-bit bit-reversal helper for the
// FFT32 output stage.
package fft_pkg;

    localparam int N     = 32;
    localparam int LANES = 4;
    localparam int BEATS = 8;
    localparam int ADDRW = 5;
    localparam int BEATW = 3;

    typedef enum logic { W_IDLE, W_FILL  } wr_state_e;
    typedef enum logic { R_IDLE, R_DRAIN } rd_state_e;

    // Life cycle of one ping-pong bank.
    typedef enum logic [1:0] {
        B_EMPTY,
        B_FILL,
        B_FULL,
        B_DRAIN
    } bank_state_e;

    function automatic logic [ADDRW-1:0] bitrev5(input logic [ADDRW-1:0] a);
        logic [ADDRW-1:0] r;
        for (int i = 0; i < ADDRW; i++) begin
            r[i] = a[ADDRW-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pa2se_bank.sv
// One 32-sample bank: writes a row of 4 complex samples per cycle, reads one
// complex sample per cycle into an output register.
module fft_pa2se_bank
    import fft_pkg::*;
#(
    parameter int nb = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [BEATW-1:0]      wrow,
    input  logic [LANES*nb-1:0]   wdr,
    input  logic [LANES*nb-1:0]   wdi,
    input  logic                  re,
    input  logic [ADDRW-1:0]      raddr,
    output logic [nb-1:0]         rdr,
    output logic [nb-1:0]         rdi
);

    logic [2*nb-1:0] mem [N];
    logic [2*nb-1:0] rdata_d;
    logic [2*nb-1:0] rdata_q;

    // Row r holds samples 4r..4r+3, so lane j lands at address {r, j}.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int j = 0; j < LANES; j++) begin
                mem[{wrow, 2'(j)}] <= {wdr[j*nb +: nb], wdi[j*nb +: nb]};
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdr = rdata_q[2*nb-1 -: nb];
    assign rdi = rdata_q[nb-1:0];

endmodule

// File: rtl/fft_pa2se.sv
// Parallel-to-serial stage: buffers 4-lane frames in two banks and streams one
// complex sample per cycle, optionally restoring natural order.
module fft_pa2se
    import fft_pkg::*;
#(
    parameter int nb     = 16,
    parameter bit BITREV = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [4*nb-1:0]   DR,
    input  logic [4*nb-1:0]   DI,
    output logic [nb-1:0]     OR,
    output logic [nb-1:0]     OI,
    output logic              OV,
    output logic              RDY,
    output logic              OVF,
    output logic              ERR
);

    wr_state_e        wr_state_q, wr_state_d;
    rd_state_e        rd_state_q, rd_state_d;
    bank_state_e      bank_st_q [2];
    bank_state_e      bank_st_d [2];
    logic [BEATW-1:0] beat_q, beat_d;
    logic             wbank_q, wbank_d;
    logic [ADDRW-1:0] cnt_q, cnt_d;
    logic             rbank_q, rbank_d;
    logic             ov_q, ov_d;
    logic             rdy_q, rdy_d;
    logic             osel_q, osel_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [1:0]       we;
    logic [BEATW-1:0] wrow;
    logic [1:0]       re;
    logic [ADDRW-1:0] rd_n;
    logic [ADDRW-1:0] raddr;
    logic             last_rd;
    logic [1:0]       bank_free;
    logic [nb-1:0]    b0_re, b0_im, b1_re, b1_im;

    // A bank whose final sample is read this cycle may be claimed by START now.
    assign last_rd      = (rd_state_q == R_DRAIN) && (cnt_q == 5'd31);
    assign bank_free[0] = (bank_st_q[0] == B_EMPTY) || (last_rd && !rbank_q);
    assign bank_free[1] = (bank_st_q[1] == B_EMPTY) || (last_rd &&  rbank_q);
    assign raddr        = BITREV ? bitrev5(rd_n) : rd_n;

    always_comb begin
        wr_state_d = wr_state_q;
        rd_state_d = rd_state_q;
        bank_st_d  = bank_st_q;
        beat_d     = beat_q;
        wbank_d    = wbank_q;
        cnt_d      = cnt_q;
        rbank_d    = rbank_q;
        osel_d     = osel_q;
        ov_d       = 1'b0;
        rdy_d      = 1'b0;
        ovf_d      = 1'b0;
        err_d      = 1'b0;
        we         = 2'b00;
        wrow       = '0;
        re         = 2'b00;
        rd_n       = '0;

        // Only one bank can complete per cycle, so at most one is full while idle.
        case (rd_state_q)
            R_IDLE: begin
                if (bank_st_q[0] == B_FULL || bank_st_q[1] == B_FULL) begin
                    rbank_d             = (bank_st_q[0] == B_FULL) ? 1'b0 : 1'b1;
                    re[rbank_d]         = 1'b1;
                    rd_n                = '0;
                    ov_d                = 1'b1;
                    rdy_d               = 1'b1;
                    osel_d              = rbank_d;
                    bank_st_d[rbank_d]  = B_DRAIN;
                    cnt_d               = 5'd1;
                    rd_state_d          = R_DRAIN;
                end
            end
            R_DRAIN: begin
                re[rbank_q] = 1'b1;
                rd_n        = cnt_q;
                ov_d        = 1'b1;
                rdy_d       = (cnt_q == 5'd0);
                osel_d      = rbank_q;
                cnt_d       = cnt_q + 5'd1;
                if (last_rd) begin
                    bank_st_d[rbank_q] = B_EMPTY;
                    if (bank_st_q[~rbank_q] == B_FULL) begin
                        rbank_d             = ~rbank_q;
                        bank_st_d[~rbank_q] = B_DRAIN;
                        cnt_d               = 5'd0;
                    end else begin
                        rd_state_d = R_IDLE;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        // Writer runs after the reader so a claim overrides a same-cycle release.
        case (wr_state_q)
            W_IDLE: begin
                if (START) begin
                    if (bank_free[0] || bank_free[1]) begin
                        wbank_d            = bank_free[0] ? 1'b0 : 1'b1;
                        we[wbank_d]        = 1'b1;
                        wrow               = '0;
                        bank_st_d[wbank_d] = B_FILL;
                        beat_d             = 3'd1;
                        wr_state_d         = W_FILL;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            W_FILL: begin
                we[wbank_q] = 1'b1;
                wrow        = beat_q;
                err_d       = START;
                beat_d      = beat_q + 3'd1;
                if (beat_q == 3'(BEATS-1)) begin
                    bank_st_d[wbank_q] = B_FULL;
                    wr_state_d         = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_state_q   <= W_IDLE;
            rd_state_q   <= R_IDLE;
            bank_st_q[0] <= B_EMPTY;
            bank_st_q[1] <= B_EMPTY;
            beat_q       <= '0;
            wbank_q      <= 1'b0;
            cnt_q        <= '0;
            rbank_q      <= 1'b0;
            osel_q       <= 1'b0;
            ov_q         <= 1'b0;
            rdy_q        <= 1'b0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            rd_state_q   <= rd_state_d;
            bank_st_q[0] <= bank_st_d[0];
            bank_st_q[1] <= bank_st_d[1];
            beat_q       <= beat_d;
            wbank_q      <= wbank_d;
            cnt_q        <= cnt_d;
            rbank_q      <= rbank_d;
            osel_q       <= osel_d;
            ov_q         <= ov_d;
            rdy_q        <= rdy_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
        end
    end

    fft_pa2se_bank #(.nb(nb)) u_bank0 (
        .clk   (CLK),
        .we    (we[0]),
        .wrow  (wrow),
        .wdr   (DR),
        .wdi   (DI),
        .re    (re[0]),
        .raddr (raddr),
        .rdr   (b0_re),
        .rdi   (b0_im)
    );

    fft_pa2se_bank #(.nb(nb)) u_bank1 (
        .clk   (CLK),
        .we    (we[1]),
        .wrow  (wrow),
        .wdr   (DR),
        .wdi   (DI),
        .re    (re[1]),
        .raddr (raddr),
        .rdr   (b1_re),
        .rdi   (b1_im)
    );

    // Bank read registers are not reset; gating by ov_q keeps outputs at zero.
    assign OR  = ov_q ? (osel_q ? b1_re : b0_re) : '0;
    assign OI  = ov_q ? (osel_q ? b1_im : b0_im) : '0;
    assign OV  = ov_q;
    assign RDY = rdy_q;
    assign OVF = ovf_q;
    assign ERR = err_q;

endmodule

// File: tb/tb_fft_pa2se.sv
// Bench for fft_pa2se: a frame-scheduling reference model predicts every output
// cycle of a BITREV=0 and a BITREV=1 instance driven with the same frames.
module tb_fft_pa2se;
    import fft_pkg::*;

    localparam int NB   = 16;
    localparam int MAXC = 512;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [4*NB-1:0] dr    = '0;
    logic [4*NB-1:0] di    = '0;

    logic [NB-1:0] or0, oi0, or1, oi1;
    logic          ov0, rdy0, ovf0, err0, ov1, rdy1, ovf1, err1;

    always #5 clk = ~clk;

    fft_pa2se #(.nb(NB), .BITREV(1'b0)) dut0 (
        .CLK(clk), .RST(rst_n), .START(start), .DR(dr), .DI(di),
        .OR(or0), .OI(oi0), .OV(ov0), .RDY(rdy0), .OVF(ovf0), .ERR(err0)
    );

    fft_pa2se #(.nb(NB), .BITREV(1'b1)) dut1 (
        .CLK(clk), .RST(rst_n), .START(start), .DR(dr), .DI(di),
        .OR(or1), .OI(oi1), .OV(ov1), .RDY(rdy1), .OVF(ovf1), .ERR(err1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Per-cycle stimulus and expectations of the current scenario.
    logic            st_a  [MAXC];
    logic [4*NB-1:0] dr_a  [MAXC];
    logic [4*NB-1:0] di_a  [MAXC];
    logic            e_ov  [MAXC];
    logic            e_rdy [MAXC];
    logic            e_ovf [MAXC];
    logic            e_err [MAXC];
    logic [NB-1:0]   e_or0 [MAXC];
    logic [NB-1:0]   e_oi0 [MAXC];
    logic [NB-1:0]   e_or1 [MAXC];
    logic [NB-1:0]   e_oi1 [MAXC];
    int              rel [2];
    int              last_ds;
    int              len;

    // Observations of the last run.
    int              frames_seen, ovf_seen, err_seen, first_ov, last_ov;
    logic [NB-1:0]   got0_q[$];
    logic [NB-1:0]   got1_q[$];
    logic [NB-1:0]   exp_q[$];

    typedef struct {
        string name;
        int    nframes;
        int    gap;
        int    mode;
        int    err_beat;
        int    exp_frames;
        int    exp_ovf;
        int    exp_err;
    } scen_t;

    scen_t tbl [6];

    task automatic check_val(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic check_zero(input string nm);
        n_cmp++;
        if ({ov0, rdy0, ovf0, err0, or0, oi0, ov1, rdy1, ovf1, err1, or1, oi1} !== '0) begin
            n_fail++;
            $display("FAIL %s got ov=%b/%b rdy=%b/%b or=%h/%h oi=%h/%h exp all zero",
                     nm, ov0, ov1, rdy0, rdy1, or0, or1, oi0, oi1);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < MAXC; c++) begin
            st_a[c]  = 1'b0;
            dr_a[c]  = '0;
            di_a[c]  = '0;
            e_ov[c]  = 1'b0;
            e_rdy[c] = 1'b0;
            e_ovf[c] = 1'b0;
            e_err[c] = 1'b0;
            e_or0[c] = '0;
            e_oi0[c] = '0;
            e_or1[c] = '0;
            e_oi1[c] = '0;
        end
        rel[0]  = -1000;
        rel[1]  = -1000;
        last_ds = -1000;
        len     = 0;
    endtask

    // Frame scheduling: a frame needs a bank whose last read is no later than
    // its START; draining begins 8 cycles after START or right after the
    // previous frame, whichever is later, and occupies 32 cycles.
    task automatic add_frame(input int s, input int mode, input int err_beat);
        logic [NB-1:0] fre [N];
        logic [NB-1:0] fim [N];
        int b;
        int ds;
        for (int i = 0; i < N; i++) begin
            case (mode)
                1:       begin fre[i] = NB'(i);               fim[i] = NB'(100 + i); end
                2:       begin fre[i] = NB'(bitrev5(5'(i)));  fim[i] = NB'(100 + i); end
                default: begin fre[i] = NB'($urandom);         fim[i] = NB'($urandom); end
            endcase
        end
        for (int k = 0; k < BEATS; k++) begin
            for (int j = 0; j < LANES; j++) begin
                dr_a[s+k][j*NB +: NB] = fre[LANES*k + j];
                di_a[s+k][j*NB +: NB] = fim[LANES*k + j];
            end
        end
        st_a[s] = 1'b1;
        if (err_beat > 0) st_a[s+err_beat] = 1'b1;
        b = -1;
        if (s >= rel[0])      b = 0;
        else if (s >= rel[1]) b = 1;
        if (b < 0) begin
            e_ovf[s+1] = 1'b1;
        end else begin
            ds      = (s + 8 > last_ds + 32) ? s + 8 : last_ds + 32;
            rel[b]  = ds + 31;
            last_ds = ds;
            for (int n = 0; n < N; n++) begin
                e_ov[ds+1+n]  = 1'b1;
                e_rdy[ds+1+n] = (n == 0);
                e_or0[ds+1+n] = fre[n];
                e_oi0[ds+1+n] = fim[n];
                e_or1[ds+1+n] = fre[bitrev5(5'(n))];
                e_oi1[ds+1+n] = fim[bitrev5(5'(n))];
            end
            if (err_beat > 0) e_err[s+err_beat+1] = 1'b1;
            if (ds + 34 > len) len = ds + 34;
        end
        if (s + 10 > len) len = s + 10;
    endtask

    task automatic do_reset();
        start = 1'b0;
        dr    = '0;
        di    = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_cycle(input int c);
        logic [2*NB+3:0] g, x;
        g = {ov0, rdy0, ovf0, err0, or0, oi0};
        x = {e_ov[c], e_rdy[c], e_ovf[c], e_err[c], e_or0[c], e_oi0[c]};
        n_cmp++;
        if (g !== x) begin
            n_fail++;
            $display("FAIL rev0_cycle%0d got=%h exp=%h (ov,rdy,ovf,err,or,oi)", c, g, x);
        end
        g = {ov1, rdy1, ovf1, err1, or1, oi1};
        x = {e_ov[c], e_rdy[c], e_ovf[c], e_err[c], e_or1[c], e_oi1[c]};
        n_cmp++;
        if (g !== x) begin
            n_fail++;
            $display("FAIL rev1_cycle%0d got=%h exp=%h (ov,rdy,ovf,err,or,oi)", c, g, x);
        end
    endtask

    // Cycle c: inputs driven just after its rising edge, outputs checked at its
    // falling edge. abort_at >= 0 pulls reset mid-cycle and stops the run.
    task automatic run_cycles(input int abort_at);
        frames_seen = 0;
        ovf_seen    = 0;
        err_seen    = 0;
        first_ov    = -1;
        last_ov     = -1;
        got0_q.delete();
        got1_q.delete();
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            start = st_a[c];
            dr    = dr_a[c];
            di    = di_a[c];
            @(negedge clk);
            check_cycle(c);
            if (ov0 && rdy0) frames_seen++;
            if (ovf0) ovf_seen++;
            if (err0) err_seen++;
            if (ov0) begin
                if (first_ov < 0) first_ov = c;
                last_ov = c;
                got0_q.push_back(or0);
                got1_q.push_back(or1);
            end
            if (c == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_zero("async_reset_mid_drain");
                break;
            end
        end
        start = 1'b0;
        dr    = '0;
        di    = '0;
    endtask

    task automatic check_order(input string nm, input logic [NB-1:0] got[$]);
        logic [NB-1:0] g;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(NB'(i));
        check_val({nm, "_count"}, got.size(), N);
        for (int i = 0; i < N && i < got.size(); i++) begin
            g = got[i];
            check_val($sformatf("%s_s%0d", nm, i), int'(g), int'(exp_q.pop_front()));
        end
    endtask

    initial begin
        tbl[0] = '{"single_idx", 1, 32, 1, -1,  1, 0, 0};
        tbl[1] = '{"single_rev", 1, 32, 2, -1,  1, 0, 0};
        tbl[2] = '{"gap32_x10", 10, 32, 0, -1, 10, 0, 0};
        tbl[3] = '{"gap8_x8",    8,  8, 0, -1,  3, 5, 0};
        tbl[4] = '{"gap16_x6",   6, 16, 0, -1,  4, 2, 0};
        tbl[5] = '{"err_beat3",  1, 32, 0,  3,  1, 0, 1};

        #1 rst_n = 1'b0;
        #1 check_zero("reset_state");
        do_reset();

        for (int t = 0; t < 6; t++) begin
            clear_model();
            for (int f = 0; f < tbl[t].nframes; f++) begin
                add_frame(f * tbl[t].gap, tbl[t].mode, tbl[t].err_beat);
            end
            run_cycles(-1);
            check_val({tbl[t].name, "_frames"}, frames_seen, tbl[t].exp_frames);
            check_val({tbl[t].name, "_ovf"},    ovf_seen,    tbl[t].exp_ovf);
            check_val({tbl[t].name, "_err"},    err_seen,    tbl[t].exp_err);
            if (t == 0) begin
                check_val("idx_first_ov", first_ov, 9);
                check_val("idx_last_ov",  last_ov,  40);
                check_order("idx_rev0", got0_q);
            end
            if (t == 1) check_order("rev_natural", got1_q);
            do_reset();
        end

        // Reset while sample 15 of a frame is on the output, then a clean frame.
        clear_model();
        add_frame(0, 1, -1);
        run_cycles(24);
        do_reset();
        clear_model();
        add_frame(0, 1, -1);
        run_cycles(-1);
        check_val("post_reset_first_ov", first_ov, 9);
        check_val("post_reset_last_ov",  last_ov,  40);
        check_val("post_reset_frames",   frames_seen, 1);
        check_order("post_reset_rev0", got0_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
